// File: rtl/cdc_hs_src.sv
// rtl/cdc_hs_src.sv - source endpoint of a four-phase req/ack clock-domain-crossing handshake
module cdc_hs_src #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             ack_s;
    logic             accept;
    logic             timeout_hit;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync_q;
    // The synchroniser restarts from 0 on reset, so ready is held off until the
    // chain has refilled with the real ack_i level; a stale ack is then seen.
    logic [SYNC_STAGES-1:0] primed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_sync_q <= '0;
            primed_q   <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
            primed_q   <= {primed_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ack_s   = ack_sync_q[SYNC_STAGES-1];
    assign ready_o = (state_q == IDLE) && !ack_s && !rst_i && primed_q[SYNC_STAGES-1];
    assign accept  = valid_i && ready_o;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    cnt_q <= '0;
                end else if ((state_q == REQ) && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign timeout_hit = (state_q == REQ) && (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = data_i;
                    req_d   = 1'b1;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A real ack takes priority over an expiring timeout.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = DRAIN;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = !err_q;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign req_o  = req_q;
    assign data_o = data_q;
    assign err_o  = err_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_hs_src.sv
// tb/tb_cdc_hs_src.sv - scoreboard bench for cdc_hs_src
module tb_cdc_hs_src;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 10;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [WIDTH-1:0] data_i = '0;
    logic             req_o;
    logic [WIDTH-1:0] data_o;
    logic             ack_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [WIDTH-1:0] exp_q[$];

    cdc_hs_src #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .req_o  (req_o),
        .data_o (data_o),
        .ack_i  (ack_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop the expected word on each req_o rise, hold it while req_o stays high.
    logic             req_prev = 1'b0;
    logic [WIDTH-1:0] held = '0;
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (req_o && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'(req_o), 32'd0);
            end else begin
                held = exp_q.pop_front();
                check("data_on_req", 32'(data_o), 32'(held));
            end
        end else if (req_o) begin
            check("data_stable", 32'(data_o), 32'(held));
        end
        req_prev = req_o;
    end

    task automatic send(input logic [WIDTH-1:0] d, input bit keep);
        int n = 0;
        data_i  = d;
        valid_i = 1'b1;
        while (!ready_o && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            check("accept_wait", 32'(n), 32'd0);
            valid_i = 1'b0;
            return;
        end
        exp_q.push_back(d);
        step();
        if (!keep) valid_i = 1'b0;
        check("req_after_accept", 32'(req_o), 32'd1);
        check("busy_after_accept", 32'(busy_o), 32'd1);
        check("ready_after_accept", 32'(ready_o), 32'd0);
    endtask

    task automatic ack_cycle(input int delay);
        int n = 0;
        repeat (delay) step();
        ack_i = 1'b1;
        while (req_o && n < 20) begin
            step();
            n++;
        end
        check("req_fall_latency", 32'(n), 32'(SYNC_STAGES + 1));
        check("err_after_ack", 32'(err_o), 32'd0);
        repeat (3) step();
        ack_i = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            step();
            n++;
        end
        check("done_latency", 32'(n), 32'(SYNC_STAGES + 1));
        check("ready_on_done", 32'(ready_o), 32'd1);
        check("busy_on_done", 32'(busy_o), 32'd0);
        exp_done++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset values
        repeat (3) step();
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b0;
        repeat (SYNC_STAGES) step();
        check("ready_after_reset", 32'(ready_o), 32'd1);

        // Basic transfer
        send(8'hA5, 1'b0);
        ack_cycle(3);
        step();
        check("done_single_pulse", 32'(done_o), 32'd0);
        check("data_kept", 32'(data_o), 32'hA5);

        // Back-to-back with valid_i held high
        for (int i = 1; i <= 4; i++) begin
            send(WIDTH'(i), 1'b1);
            ack_cycle(3);
        end
        valid_i = 1'b0;
        step();
        check("b2b_done_count", 32'(done_cnt), 32'(exp_done));
        check("b2b_last_data", 32'(data_o), 32'h04);

        // Stall protection: valid_i pulse while busy
        send(8'h55, 1'b0);
        step();
        valid_i = 1'b1;
        data_i  = 8'h3C;
        step();
        valid_i = 1'b0;
        check("stall_data", 32'(data_o), 32'h55);
        ack_cycle(1);
        repeat (3) step();
        check("stall_no_req", 32'(req_o), 32'd0);
        check("stall_data_hold", 32'(data_o), 32'h55);

        // Timeout
        send(8'h99, 1'b0);
        n = 0;
        while (req_o && n < 30) begin
            step();
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TIMEOUT));
        check("timeout_err", 32'(err_o), 32'd1);
        repeat (5) step();
        check("err_sticky", 32'(err_o), 32'd1);
        check("timeout_no_done", 32'(done_cnt), 32'(exp_done));
        check("ready_after_timeout", 32'(ready_o), 32'd1);
        send(8'h5A, 1'b0);
        check("err_cleared", 32'(err_o), 32'd0);
        ack_cycle(3);

        // Ack and timeout in the same cycle: ack wins
        send(8'hC3, 1'b0);
        ack_cycle(TIMEOUT - SYNC_STAGES - 1);
        check("collision_err", 32'(err_o), 32'd0);

        // Reset mid-REQ with ack_i high
        send(8'h77, 1'b0);
        ack_i = 1'b1;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_req", 32'(req_o), 32'd0);
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd0);
        repeat (3) step();
        check("stale_ack_ready", 32'(ready_o), 32'd0);
        ack_i = 1'b0;
        step();
        check("ready_1_after_drop", 32'(ready_o), 32'd0);
        step();
        check("ready_2_after_drop", 32'(ready_o), 32'd1);
        check("midrst_done", 32'(done_cnt), 32'(exp_done));

        // Post-reset transfer still works
        send(8'h3E, 1'b0);
        ack_cycle(3);
        step();
        check("final_done_count", 32'(done_cnt), 32'(exp_done));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
